div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 clk  input  1  single system clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset; forces the reset state immediately, independent of clk.
REQ-003 start  input  1  request to begin a division; sampled only in IDLE.
REQ-004 dvsr  input  8  divisor, unsigned; sampled on the accepting edge.
REQ-005 dvnd  input  8  dividend, unsigned; sampled on the accepting edge.
REQ-006 ready  output  1  high exactly while in IDLE (able to accept start).
REQ-007 done_tick  output  1  one-cycle pulse, high exactly while in DONE.
REQ-008 quo  output  8  quotient register, unsigned.
REQ-009 rmd  output  8  remainder register, unsigned.
REQ-010 Parameter W, default 8: operand/result width; all widths above equal W; counter width = ceil(log2(W+1)).

Function
REQ-011 FSM states SHALL be IDLE, OP, DONE; the encoding is free; ready and done_tick are Moore outputs.
REQ-012 IDLE + start=1 at an edge SHALL latch dvsr into divisor reg D, dvnd into shift reg RL, clear partial remainder RH, load counter n=W, and go to OP.
REQ-013 IDLE + start=0 SHALL stay in IDLE with all registers held.
REQ-014 Each OP cycle SHALL perform one restoring step:
- T = {RH, RL[W-1]} (W+1 bits).
- if T >= {0,D}: RH <= T-D, qbit=1; else RH <= T[W-1:0], qbit=0.
- RL <= {RL[W-2:0], qbit}; n <= n-1.
REQ-015 OP with n=1 SHALL go to DONE after that step; otherwise stay in OP.
REQ-016 quo SHALL be RL and rmd SHALL be RH, both continuously driven.
REQ-017 Results SHALL be valid from the first DONE cycle and held unchanged until the next accepted start.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-019 Latency: accept edge -> exactly W OP cycles -> 1 DONE cycle; accept edge + (W+1) clocks = done_tick high; then one IDLE cycle.
REQ-020 With start held high continuously, a new operation SHALL be accepted on every IDLE cycle (period W+2 = 10 clocks for W=8).
REQ-021 start, dvsr and dvnd SHALL be ignored outside IDLE; input changes during OP/DONE SHALL not affect the result in progress.
REQ-022 Results SHALL satisfy dvnd = quo*dvsr + rmd with rmd < dvsr whenever dvsr != 0.
REQ-023 dvsr=0 SHALL follow the same algorithm with no special case: quo=all ones, rmd=dvnd, same latency.
REQ-024 dvnd < dvsr SHALL yield quo=0, rmd=dvnd.

Reset
REQ-025 On reset assertion: state=IDLE, RL=RH=D=0, n=0, so ready=1, done_tick=0, quo=0, rmd=0.
REQ-026 Reset asserted mid-operation (OP or DONE) SHALL abort it with no done_tick.
REQ-027 Normal operation SHALL resume on the first rising edge after reset deasserts.

Verification
REQ-028 The bench SHALL cover these scenarios:
- dvnd=14, dvsr=3, start pulse -> done_tick 9 clocks after the accept edge; quo=4, rmd=2; ready low during OP/DONE.
- start held high: 14/3, then 13/2, then 32/3 -> quo/rmd 4/2, 6/1, 10/2; successive done_tick pulses 10 clocks apart.
- 255/1 -> 255/0; 5/9 -> 0/5; 255/255 -> 1/0.
- dvnd=77, dvsr=0 -> quo=255, rmd=77, normal latency.
- reset pulse at the 4th OP cycle -> immediate ready=1, quo=rmd=0, no done_tick; next 200/7 -> 28/4.
- Change dvnd/dvsr during OP -> result reflects the latched operands only.

Source files
------------

// File: rtl/div.sv
// Sequential restoring divider: one quotient bit per clock, W OP cycles per division.
// Handshake is start/ready on the way in and a one-cycle done_tick on the way out.
module div #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dvsr,
    input  logic [W-1:0] dvnd,
    output logic         ready,
    output logic         done_tick,
    output logic [W-1:0] quo,
    output logic [W-1:0] rmd
);

    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        StIdle,
        StOp,
        StDone
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] d_q, d_d;     // latched divisor
    logic [W-1:0] rl_q, rl_d;   // dividend shifting out, quotient shifting in
    logic [W-1:0] rh_q, rh_d;   // partial remainder
    logic [CW-1:0] n_q, n_d;    // steps left

    logic [W:0] t;
    logic [W:0] t_sub;
    logic       q_bit;

    // One restoring step: bring in the next dividend bit and trial-subtract the divisor.
    always_comb begin
        t     = {rh_q, rl_q[W-1]};
        t_sub = t - {1'b0, d_q};
        q_bit = (t >= {1'b0, d_q});
    end

    // Next-state and Moore outputs; every register holds unless its state updates it.
    always_comb begin
        state_d   = state_q;
        d_d       = d_q;
        rl_d      = rl_q;
        rh_d      = rh_q;
        n_d       = n_q;
        ready     = 1'b0;
        done_tick = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    d_d     = dvsr;
                    rl_d    = dvnd;
                    rh_d    = '0;
                    n_d     = CW'(W);
                    state_d = StOp;
                end
            end
            StOp: begin
                rh_d = q_bit ? t_sub[W-1:0] : t[W-1:0];
                rl_d = {rl_q[W-2:0], q_bit};
                n_d  = n_q - CW'(1);
                if (n_q == CW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_tick = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            d_q     <= '0;
            rl_q    <= '0;
            rh_q    <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            rl_q    <= rl_d;
            rh_q    <= rh_d;
            n_q     <= n_d;
        end
    end

    assign quo = rl_q;
    assign rmd = rh_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: scoreboard of expected quo/rmd pushed at accept time.
module tb_div;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dvsr;
    logic [W-1:0] dvnd;
    logic         ready;
    logic         done_tick;
    logic [W-1:0] quo;
    logic [W-1:0] rmd;

    int tests;
    int fails;

    logic [2*W-1:0] sb_q[$];  // {quo, rmd}

    div #(
        .W(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dvsr     (dvsr),
        .dvnd     (dvnd),
        .ready    (ready),
        .done_tick(done_tick),
        .quo      (quo),
        .rmd      (rmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ordinary integer division; a zero divisor yields all ones and the dividend.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {{W{1'b1}}, a};
        return {a / b, a % b};
    endfunction

    // Drive one start pulse from a negedge; returns after the accepting posedge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dvnd  = a;
        dvsr  = b;
        start = 1'b1;
        sb_q.push_back(model(a, b));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges from the accept edge until done_tick; lat = 0 on timeout.
    // The first negedge after accept was consumed by accept(), so counting starts at 1.
    task automatic wait_done(output int lat, output int ready_bad);
        lat       = 0;
        ready_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (ready !== 1'b0) ready_bad++;
            if (done_tick === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_result(input string name);
        logic [2*W-1:0] exp;
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty, got quo=%0d rmd=%0d", name, quo, rmd);
            return;
        end
        exp = sb_q.pop_front();
        if ({quo, rmd} !== exp) begin
            fails++;
            $display("FAIL %s: got quo=%0d rmd=%0d, want quo=%0d rmd=%0d",
                     name, quo, rmd, exp[2*W-1:W], exp[W-1:0]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        dvnd  = '0;
        dvsr  = '0;
        #2;
        tests++;
        if ({ready, done_tick, quo, rmd} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
            fails++;
            $display("FAIL reset_state: got ready=%b done=%b quo=%0d rmd=%0d, want 1 0 0 0",
                     ready, done_tick, quo, rmd);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, rb;
        accept(8'd14, 8'd3);
        wait_done(lat, rb);
        tests++;
        if (lat != 9) begin
            fails++;
            $display("FAIL basic_latency: got %0d clocks, want 9", lat);
        end
        tests++;
        if (rb != 0) begin
            fails++;
            $display("FAIL basic_ready_busy: ready high %0d busy cycles, want 0", rb);
        end
        check_result("basic_14_3");
        @(negedge clk);
        tests++;
        if ({ready, done_tick, quo, rmd} !== {1'b1, 1'b0, 8'd4, 8'd2}) begin
            fails++;
            $display("FAIL basic_hold: got ready=%b done=%b quo=%0d rmd=%0d, want 1 0 4 2",
                     ready, done_tick, quo, rmd);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a_tab[3];
        logic [W-1:0] b_tab[3];
        int pushed, seen, last, cyc;
        a_tab  = '{8'd14, 8'd13, 8'd32};
        b_tab  = '{8'd3, 8'd2, 8'd3};
        pushed = 0;
        seen   = 0;
        last   = -1;
        for (cyc = 0; cyc < 60 && seen < 3; cyc++) begin
            @(negedge clk);
            if (done_tick === 1'b1) begin
                check_result("b2b_result");
                if (last >= 0) begin
                    tests++;
                    if (cyc - last != 10) begin
                        fails++;
                        $display("FAIL b2b_period: got %0d clocks, want 10", cyc - last);
                    end
                end
                last = cyc;
                seen++;
            end
            if (ready === 1'b1 && pushed < 3) begin
                dvnd  = a_tab[pushed];
                dvsr  = b_tab[pushed];
                start = 1'b1;
                sb_q.push_back(model(a_tab[pushed], b_tab[pushed]));
                pushed++;
            end else if (ready !== 1'b1 && pushed == 3) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        tests++;
        if (seen != 3) begin
            fails++;
            $display("FAIL b2b_count: got %0d done pulses, want 3", seen);
        end
    endtask

    task automatic test_corners();
        logic [W-1:0] a_tab[5];
        logic [W-1:0] b_tab[5];
        int lat, rb;
        a_tab = '{8'd255, 8'd5, 8'd255, 8'd77, 8'd0};
        b_tab = '{8'd1, 8'd9, 8'd255, 8'd0, 8'd7};
        for (int i = 0; i < 5; i++) begin
            accept(a_tab[i], b_tab[i]);
            wait_done(lat, rb);
            tests++;
            if (lat != 9) begin
                fails++;
                $display("FAIL corner_latency[%0d]: got %0d clocks, want 9", i, lat);
            end
            check_result("corner_result");
        end
    endtask

    task automatic test_abort();
        int seen_done;
        accept(8'd100, 8'd3);
        // accept() left us on the first OP negedge; advance to the 4th.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if ({ready, done_tick, quo, rmd} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
            fails++;
            $display("FAIL abort_state: got ready=%b done=%b quo=%0d rmd=%0d, want 1 0 0 0",
                     ready, done_tick, quo, rmd);
        end
        void'(sb_q.pop_back());
        @(negedge clk);
        reset     = 1'b0;
        seen_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_tick === 1'b1) seen_done++;
        end
        tests++;
        if (seen_done != 0) begin
            fails++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", seen_done);
        end
        begin
            int lat, rb;
            accept(8'd200, 8'd7);
            wait_done(lat, rb);
            tests++;
            if (lat != 9) begin
                fails++;
                $display("FAIL abort_resume_latency: got %0d clocks, want 9", lat);
            end
            check_result("abort_resume_200_7");
        end
    endtask

    task automatic test_input_change();
        int lat;
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            accept(8'(40 + 37 * i), 8'(3 + 2 * i));
            // Scramble operands and strobe start while busy; start drops before IDLE.
            for (int k = 1; k <= 40; k++) begin
                if (k > 1) @(negedge clk);
                if (done_tick === 1'b1) begin
                    lat = k;
                    break;
                end
                dvnd  = 8'($urandom);
                dvsr  = 8'($urandom);
                start = (k < 7) ? 1'($urandom) : 1'b0;
            end
            start = 1'b0;
            tests++;
            if (lat != 9) begin
                fails++;
                $display("FAIL change_latency[%0d]: got %0d clocks, want 9", i, lat);
            end
            check_result("change_result");
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_corners();
        test_abort();
        test_input_change();
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d results left, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
